alu_cmd_ctrl: RTL and testbench
===============================

ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of operands, result, RX/TX words.
REQ-002 SHALL have parameter FUN_WIDTH, default 4, width of ALU function code.
REQ-003 SHALL have parameter HEADER, default 8'hCC, frame start word (DATA_WIDTH bits).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, response wait limit (ALU_TIMEOUT_EN only).
REQ-005 SHALL have port CLK  input  1  clock, rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port RX_DATA  input  DATA_WIDTH  incoming command word.
REQ-008 SHALL have port RX_VALID  input  1  RX_DATA valid this cycle, single-cycle pulse per word.
REQ-009 SHALL have port ALU_EN  output  1  ALU operation strobe.
REQ-010 SHALL have port ALU_FUN  output  FUN_WIDTH  ALU function code.
REQ-011 SHALL have port A  output  DATA_WIDTH  operand A.
REQ-012 SHALL have port B  output  DATA_WIDTH  operand B.
REQ-013 SHALL have port ALU_OUT  input  DATA_WIDTH  ALU registered result.
REQ-014 SHALL have port ALU_OUT_VALID  input  1  ALU result valid.
REQ-015 SHALL have port TX_DATA  output  DATA_WIDTH  result word to sender.
REQ-016 SHALL have port TX_VALID  output  1  TX_DATA valid.
REQ-017 SHALL have port TX_READY  input  1  sender accepts TX_DATA.
REQ-018 SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-019 SHALL have port RX_DROP  output  1  one-cycle pulse when an RX word is discarded outside IDLE/GET states.

Function
REQ-020 SHALL implement FSM states IDLE, GET_A, GET_B, GET_FUN, EXEC, WAIT, SEND.
REQ-021 IDLE: RX_VALID with RX_DATA==HEADER -> GET_A; any other word ignored silently, stay IDLE.
REQ-022 GET_A/GET_B: RX_VALID latches RX_DATA into A/B register, advance to GET_B/GET_FUN; no RX_VALID -> hold state indefinitely.
REQ-023 GET_FUN: RX_VALID latches RX_DATA[FUN_WIDTH-1:0] into ALU_FUN (upper bits discarded) -> EXEC.
REQ-024 EXEC: ALU_EN=1 for exactly this one cycle -> WAIT; ALU_EN=0 in all other states.
REQ-025 A, B, ALU_FUN SHALL hold stable from latch until next frame overwrites them.
REQ-026 WAIT: ALU_OUT_VALID=1 captures ALU_OUT into TX_DATA register -> SEND; with ideal registered ALU, TX_VALID rises 2 cycles after ALU_EN cycle.
REQ-027 ALU_OUT_VALID outside WAIT SHALL be ignored.
REQ-028 SEND: TX_VALID=1, TX_DATA stable until cycle with TX_READY=1; that cycle is the transfer, next state IDLE, TX_VALID=0 next cycle.
REQ-029 TX_READY high on entering SEND SHALL complete transfer in first SEND cycle (one-cycle TX_VALID).
REQ-030 RX_VALID in EXEC, WAIT or SEND SHALL be discarded and pulse RX_DROP next cycle; frame bytes are not buffered.
REQ-031 A HEADER value received in GET_A/GET_B/GET_FUN SHALL be treated as data, not resync.
REQ-032 Back-to-back frames: HEADER accepted in the cycle after SEND->IDLE transition.

Reset
REQ-033 RST low SHALL asynchronously force state IDLE from any state, including mid-frame and mid-SEND.
REQ-034 Reset values: ALU_EN=0, ALU_FUN=0, A=0, B=0, TX_DATA=0, TX_VALID=0, BUSY=0, RX_DROP=0, timeout counter 0.
REQ-035 Partial frame in progress at reset SHALL be lost; no TX occurs for it.

Configuration
REQ-036 Macro ALU_TIMEOUT_EN defined: WAIT counts cycles; reaching TIMEOUT_CYCLES without ALU_OUT_VALID loads TX_DATA with all-ones -> SEND; counter clears on WAIT entry.
REQ-037 Macro ALU_TIMEOUT_EN undefined: no counter logic; WAIT holds until ALU_OUT_VALID, indefinitely.

Verification
REQ-038 RX CC,05,03,00 -> ALU_EN one cycle with A=05,B=03,FUN=0; ALU returns 08 -> TX_DATA=08, TX_VALID until TX_READY.
REQ-039 RX 11,CC,0A,02,F1 (TX_READY=1) -> 11 ignored, FUN=1, A=0A,B=02, single TX word from ALU (08), RX_DROP=0.
REQ-040 TX_READY=0 for 5 cycles in SEND -> TX_VALID held, TX_DATA stable; RX word during SEND -> RX_DROP pulse, state unchanged.
REQ-041 RST low after CC,05 -> BUSY=0, all outputs zero; then RX 07,00 -> no ALU_EN.
REQ-042 With ALU_TIMEOUT_EN, ALU_OUT_VALID held 0 -> TX_DATA=FF, TX_VALID after TIMEOUT_CYCLES WAIT cycles; without macro, BUSY stays 1 for 100 cycles.
REQ-043 Two frames back-to-back, TX_READY=1 -> two TX words in frame order, BUSY drops one cycle between.

Source files
------------

// File: rtl/alu_cmd_ctrl_if.sv
// Command/ALU/response bus between alu_cmd_ctrl and its environment.
// The slave modport is the controller's view; master is the environment's view.
interface alu_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] RX_DATA;
  logic                  RX_VALID;
  logic                  ALU_EN;
  logic [FUN_WIDTH-1:0]  ALU_FUN;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic [DATA_WIDTH-1:0] ALU_OUT;
  logic                  ALU_OUT_VALID;
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;
  logic                  BUSY;
  logic                  RX_DROP;

  modport master (
    output RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
    input  ALU_EN, ALU_FUN, A, B, TX_DATA, TX_VALID, BUSY, RX_DROP
  );

  modport slave (
    input  RX_DATA, RX_VALID, ALU_OUT, ALU_OUT_VALID, TX_READY,
    output ALU_EN, ALU_FUN, A, B, TX_DATA, TX_VALID, BUSY, RX_DROP
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Frame-to-ALU command controller: HEADER, A, B, FUN -> ALU strobe -> single TX result word.
// Optional macro ALU_TIMEOUT_EN: WAIT gives up after TIMEOUT_CYCLES and returns all-ones.
module alu_cmd_ctrl #(
  parameter int unsigned           DATA_WIDTH     = 8,
  parameter int unsigned           FUN_WIDTH      = 4,
  parameter logic [DATA_WIDTH-1:0] HEADER         = 8'hCC,
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input logic           CLK,
  input logic           RST,
  alu_cmd_ctrl_if.slave bus
);

  if (TIMEOUT_CYCLES == 0 || FUN_WIDTH > DATA_WIDTH) begin : g_bad_cfg
    $error("alu_cmd_ctrl: TIMEOUT_CYCLES must be nonzero and FUN_WIDTH <= DATA_WIDTH");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_GET_A, S_GET_B, S_GET_FUN, S_EXEC, S_WAIT, S_SEND
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [FUN_WIDTH-1:0]  fun_q, fun_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  alu_en_q, alu_en_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  busy_q, busy_d;
  logic                  rx_drop_q, rx_drop_d;

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and next-output logic; registered outputs track the state being entered.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    fun_d     = fun_q;
    tx_data_d = tx_data_q;
`ifdef ALU_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.RX_VALID && (bus.RX_DATA == HEADER)) state_d = S_GET_A;
      end
      S_GET_A: begin
        if (bus.RX_VALID) begin
          a_d     = bus.RX_DATA;
          state_d = S_GET_B;
        end
      end
      S_GET_B: begin
        if (bus.RX_VALID) begin
          b_d     = bus.RX_DATA;
          state_d = S_GET_FUN;
        end
      end
      S_GET_FUN: begin
        if (bus.RX_VALID) begin
          fun_d   = bus.RX_DATA[FUN_WIDTH-1:0];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_WAIT;
`ifdef ALU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.ALU_OUT_VALID) begin
          tx_data_d = bus.ALU_OUT;
          state_d   = S_SEND;
        end
`ifdef ALU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          tx_data_d = '1;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_SEND: begin
        if (bus.TX_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Words arriving while a result is pending are not buffered.
    rx_drop_d  = bus.RX_VALID &&
                 ((state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_SEND));
    alu_en_d   = (state_d == S_EXEC);
    tx_valid_d = (state_d == S_SEND);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      fun_q      <= '0;
      tx_data_q  <= '0;
      alu_en_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rx_drop_q  <= 1'b0;
`ifdef ALU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      fun_q      <= fun_d;
      tx_data_q  <= tx_data_d;
      alu_en_q   <= alu_en_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      rx_drop_q  <= rx_drop_d;
`ifdef ALU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  assign bus.ALU_EN   = alu_en_q;
  assign bus.ALU_FUN  = fun_q;
  assign bus.A        = a_q;
  assign bus.B        = b_q;
  assign bus.TX_DATA  = tx_data_q;
  assign bus.TX_VALID = tx_valid_q;
  assign bus.BUSY     = busy_q;
  assign bus.RX_DROP  = rx_drop_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed + randomized bench for alu_cmd_ctrl with a behavioural registered-ALU model.
module tb_alu_cmd_ctrl;
  localparam int unsigned DW  = 8;
  localparam int unsigned FW  = 4;
  localparam logic [7:0]  HDR = 8'hCC;
  localparam int unsigned TO  = 16;

  logic CLK = 1'b0;
  logic RST;
  int   nvec = 0;
  int   nerr = 0;

  always #5 CLK = ~CLK;

  alu_cmd_ctrl_if #(.DATA_WIDTH(DW), .FUN_WIDTH(FW)) bus ();

  alu_cmd_ctrl #(.DATA_WIDTH(DW), .FUN_WIDTH(FW), .HEADER(HDR), .TIMEOUT_CYCLES(TO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Reference ALU behaviour (bench-side only).
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      default: return b - a;
    endcase
  endfunction

  // Registered ALU with programmable latency; spur injects an out-of-protocol valid.
  logic [7:0] alu_res   = 8'h00;
  int         alu_pend  = 0;
  int         alu_lat   = 1;
  bit         alu_stall = 1'b0;
  bit         spur      = 1'b0;

  always @(posedge CLK) begin
    if (bus.ALU_EN) begin
      alu_res  <= alu_ref(bus.A, bus.B, bus.ALU_FUN);
      alu_pend <= alu_lat;
    end else if (alu_pend > 0) begin
      alu_pend <= alu_pend - 1;
    end
  end

  assign bus.ALU_OUT_VALID = ((alu_pend == 1) && !alu_stall) || spur;
  assign bus.ALU_OUT       = spur ? ~alu_res : alu_res;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_word(input logic [7:0] w);
    bus.RX_DATA  = w;
    bus.RX_VALID = 1'b1;
    step();
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'($urandom);
  endtask

  task automatic gap_steps(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("gap_busy", bus.BUSY, 1);
      chk("gap_alu_en", bus.ALU_EN, 0);
    end
  endtask

  // HEADER + A + B + FUN, ending with the controller in its execute cycle.
  task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input int gap);
    logic [3:0] fexp;
    fexp = f[3:0];
    put_word(HDR);
    chk("hdr_busy", bus.BUSY, 1);
    gap_steps(gap);
    put_word(a);
    chk("lat_a", bus.A, 32'(a));
    gap_steps(gap);
    put_word(b);
    chk("lat_b", bus.B, 32'(b));
    gap_steps(gap);
    put_word(f);
    chk("exec_alu_en", bus.ALU_EN, 1);
    chk("exec_fun", bus.ALU_FUN, 32'(fexp));
    chk("exec_a", bus.A, 32'(a));
    chk("exec_b", bus.B, 32'(b));
    chk("exec_rx_drop", bus.RX_DROP, 0);
  endtask

  // From the execute cycle: result after lat+1 cycles, then hold for rd cycles before acceptance.
  task automatic finish_tx(input logic [7:0] exp, input int lat, input int rd, input bit drop);
    alu_lat     = lat;
    bus.TX_READY = (rd == 0);
    for (int k = 0; k < lat; k++) begin
      step();
      chk("wait_tx_valid", bus.TX_VALID, 0);
      chk("wait_alu_en", bus.ALU_EN, 0);
      chk("wait_busy", bus.BUSY, 1);
    end
    step();
    chk("send_tx_valid", bus.TX_VALID, 1);
    chk("send_tx_data", bus.TX_DATA, 32'(exp));
    for (int j = 0; j < rd; j++) begin
      if (j == 0 && drop) begin
        bus.RX_DATA  = HDR;
        bus.RX_VALID = 1'b1;
        spur         = 1'b1;
      end
      step();
      bus.RX_VALID = 1'b0;
      spur         = 1'b0;
      chk("hold_tx_valid", bus.TX_VALID, 1);
      chk("hold_tx_data", bus.TX_DATA, 32'(exp));
      chk("hold_rx_drop", bus.RX_DROP, (j == 0 && drop) ? 1 : 0);
    end
    bus.TX_READY = 1'b1;
    step();
    bus.TX_READY = 1'b0;
    chk("done_tx_valid", bus.TX_VALID, 0);
    chk("done_busy", bus.BUSY, 0);
    chk("done_rx_drop", bus.RX_DROP, 0);
  endtask

  initial begin
    logic [7:0] a, b, f;
    int lat, rd, gap;
    bit drop;

    RST          = 1'b0;
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    bus.TX_READY = 1'b0;
    step();
    step();
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_alu_en", bus.ALU_EN, 0);
    chk("rst_a", bus.A, 0);
    chk("rst_b", bus.B, 0);
    chk("rst_fun", bus.ALU_FUN, 0);
    chk("rst_tx_data", bus.TX_DATA, 0);
    chk("rst_tx_valid", bus.TX_VALID, 0);
    chk("rst_rx_drop", bus.RX_DROP, 0);
    RST = 1'b1;
    step();

    // Basic add frame, slow receiver.
    send_frame(8'h05, 8'h03, 8'h00, 0);
    finish_tx(8'h08, 1, 2, 1'b0);

    // Leading junk ignored, upper FUN bits dropped, receiver ready on entry.
    put_word(8'h11);
    chk("junk_busy", bus.BUSY, 0);
    chk("junk_rx_drop", bus.RX_DROP, 0);
    send_frame(8'h0A, 8'h02, 8'hF1, 0);
    finish_tx(8'h08, 1, 0, 1'b0);

    // Long backpressure with a dropped word and a stray ALU valid in SEND.
    send_frame(8'h40, 8'h22, 8'h04, 1);
    finish_tx(8'h62, 1, 5, 1'b1);

    // HEADER value used as payload.
    send_frame(HDR, HDR, HDR, 0);
    finish_tx(alu_ref(HDR, HDR, 4'hC), 2, 1, 1'b0);

    // Stray ALU valid while idle is ignored.
    spur = 1'b1;
    step();
    spur = 1'b0;
    chk("idle_spur_busy", bus.BUSY, 0);
    chk("idle_spur_tx_valid", bus.TX_VALID, 0);

    // Back-to-back frames with the receiver always ready.
    send_frame(8'h10, 8'h01, 8'h00, 0);
    finish_tx(8'h11, 1, 0, 1'b0);
    send_frame(8'h10, 8'h01, 8'h01, 0);
    finish_tx(8'h0F, 1, 0, 1'b0);

    // Randomized frames.
    for (int n = 0; n < 25; n++) begin
      a    = ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom);
      b    = 8'($urandom);
      f    = 8'($urandom);
      lat  = int'($urandom_range(1, 4));
      rd   = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      drop = 1'($urandom_range(0, 1));
      if (gap > 0) gap_steps_idle(gap);
      send_frame(a, b, f, gap);
      finish_tx(alu_ref(a, b, f[3:0]), lat, rd, drop);
    end

    // Reset mid-frame clears everything; the tail of the frame does nothing.
    send_frame(8'h37, 8'h59, 8'h03, 0);
    finish_tx(8'h7F, 1, 1, 1'b0);
    put_word(HDR);
    put_word(8'h05);
    #2;
    RST = 1'b0;
    #1;
    chk("arst_busy", bus.BUSY, 0);
    chk("arst_a", bus.A, 0);
    chk("arst_b", bus.B, 0);
    chk("arst_fun", bus.ALU_FUN, 0);
    chk("arst_tx_data", bus.TX_DATA, 0);
    chk("arst_tx_valid", bus.TX_VALID, 0);
    chk("arst_alu_en", bus.ALU_EN, 0);
    step();
    RST = 1'b1;
    put_word(8'h07);
    chk("post_rst_busy0", bus.BUSY, 0);
    put_word(8'h00);
    chk("post_rst_alu_en", bus.ALU_EN, 0);
    step();
    chk("post_rst_busy1", bus.BUSY, 0);
    chk("post_rst_alu_en2", bus.ALU_EN, 0);

    // Reset while presenting a result.
    alu_lat = 1;
    send_frame(8'h21, 8'h12, 8'h00, 0);
    step();
    step();
    chk("mid_send_tx_valid", bus.TX_VALID, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("mid_send_rst_tx_valid", bus.TX_VALID, 0);
    chk("mid_send_rst_busy", bus.BUSY, 0);
    step();
    RST = 1'b1;
    bus.TX_READY = 1'b1;
    step();
    step();
    bus.TX_READY = 1'b0;
    chk("mid_send_no_tx", bus.TX_VALID, 0);

    // ALU never answers.
    alu_stall = 1'b1;
`ifdef ALU_TIMEOUT_EN
    for (int r = 0; r < 2; r++) begin
      send_frame(8'h01, 8'h02, 8'h00, 0);
      for (int k = 0; k < int'(TO); k++) begin
        step();
        chk("to_wait_tx_valid", bus.TX_VALID, 0);
      end
      step();
      chk("to_tx_valid", bus.TX_VALID, 1);
      chk("to_tx_data", bus.TX_DATA, 32'hFF);
      bus.TX_READY = 1'b1;
      step();
      bus.TX_READY = 1'b0;
      chk("to_done_busy", bus.BUSY, 0);
    end
`else
    send_frame(8'h01, 8'h02, 8'h00, 0);
    for (int k = 0; k < 100; k++) begin
      step();
      chk("hang_busy", bus.BUSY, 1);
      chk("hang_tx_valid", bus.TX_VALID, 0);
    end
    RST = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk("hang_recover_busy", bus.BUSY, 0);
`endif
    alu_stall = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  task automatic gap_steps_idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("idle_busy", bus.BUSY, 0);
    end
  endtask

endmodule
